// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mips_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the IF port, data port and memory port seen by the arbiter.
// slave = arbiter view; master = pipeline stages plus memory model.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_done;
    logic                  if_stall;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_done;
    logic                  d_stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    logic [1:0]            owner;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, owner
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, owner
    );

endinterface

// File: rtl/mem_arb_picker.sv
// Purpose: picks IF or data for the next grant; data wins unless IF has waited MAX_D_STREAK grants.
// Latency: grants are combinational; streak updates on the clock edge that takes a grant.
// Backpressure: grant_stb only pulses when the arbiter is idle, so the streak counts real grants.
module mem_arb_picker #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_stb,
    output logic grant_if,
    output logic grant_d
);

    localparam int CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    logic [CNT_W-1:0] streak;

    assign grant_d  = d_req & ~(if_req & (streak == STREAK_MAX));
    assign grant_if = if_req & ~grant_d;

    // Streak only grows while IF is actually being held off.
    always_ff @(posedge clk) begin
        if (!reset) begin
            streak <= '0;
        end else if (grant_stb) begin
            if (grant_if) begin
                streak <= '0;
            end else if (grant_d) begin
                if (!if_req) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-port variable-latency memory between IF and MEM stages.
// Latency: request sampled idle at N -> mem_req at N+1 -> done at N+2 at best; 3-cycle issue interval.
// Backpressure: mem_req and command held until mem_ready; stages stall via if_stall/d_stall until done.
module unified_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    unified_mem_arbiter_if.slave bus
);

    localparam int BE_W = DATA_W / 8;

    state_t state, state_nxt;
    logic   grant_stb, grant_if, grant_d;

    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [1:0]        owner_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_done_q, d_done_q;

    mem_arb_picker #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_picker (
        .clk      (clk),
        .reset    (reset),
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .grant_stb(grant_stb),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_stb = 1'b0;
        case (state)
            IDLE: begin
                grant_stb = bus.if_req | bus.d_req;
                if (grant_if || grant_d) state_nxt = BUSY;
            end
            BUSY:    if (bus.mem_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command is latched once at grant so requesters may change inputs freely afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            owner_q     <= OWN_NONE;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        mem_be_q    <= bus.d_we ? bus.d_be : {BE_W{1'b1}};
                        owner_q     <= OWN_D;
                    end else if (grant_if) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= {BE_W{1'b1}};
                        owner_q     <= OWN_IF;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_done_q  <= 1'b1;
                        end else begin
                            if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
                            d_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                    owner_q   <= OWN_NONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.owner     = owner_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a done-pulse scoreboard and a grant-order queue.
module tb_unified_mem_arbiter;
    import mips_mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    unified_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_D_STREAK(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] grant_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Steps until a done pulse (or budget expires), then checks it against the scoreboard head.
    task automatic wait_done(input string tag, input int budget);
        logic seen;
        logic have;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = bus.if_done | bus.d_done;
        end
        n_tests++;
        assert (seen)
        else begin
            n_fail++;
            $error("FAIL %s_timeout: observed no done, expected done within %0d cycles", tag, budget);
        end
        if (seen) begin
            have = (exp_q.size() != 0);
            n_tests++;
            assert (have)
            else begin
                n_fail++;
                $error("FAIL %s_sb: observed unexpected done, expected empty scoreboard", tag);
            end
            if (have) begin
                e = exp_q.pop_front();
                chk({tag, "_port"}, 32'({bus.d_done, bus.if_done}), 32'(e.port));
                chk({tag, "_data"}, (e.port == OWN_IF) ? bus.if_rdata : bus.d_rdata, e.data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       prev_req;
        int         grants;
        logic [1:0] eg;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_owner",   32'(bus.owner),   32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_d_done",  32'(bus.d_done),  32'd0);
        chk("rst_addr",    bus.mem_addr,     32'd0);
        chk("rst_be",      32'(bus.mem_be),  32'd0);
        chk("rst_if_rd",   bus.if_rdata,     32'd0);
        chk("rst_d_rd",    bus.d_rdata,      32'd0);

        // Single IF fetch, minimum latency
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h2001_0005;
        exp_q.push_back('{port: OWN_IF, data: 32'h2001_0005});
        #1;
        chk("t1_stall_c0", 32'(bus.if_stall), 32'd1);
        step();
        chk("t1_mem_req", 32'(bus.mem_req), 32'd1);
        chk("t1_addr",    bus.mem_addr,     32'h40);
        chk("t1_we",      32'(bus.mem_we),  32'd0);
        chk("t1_owner",   32'(bus.owner),   32'(OWN_IF));
        chk("t1_be",      32'(bus.mem_be),  32'hF);
        chk("t1_stall_c1", 32'(bus.if_stall), 32'd1);
        wait_done("t1", 1);
        chk("t1_stall_done", 32'(bus.if_stall), 32'd0);
        bus.if_req = 1'b0;
        step();
        chk("t1_owner_idle", 32'(bus.owner),   32'd0);
        chk("t1_done_clr",   32'(bus.if_done), 32'd0);

        // Both request: data store first, then IF
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.mem_rdata = 32'h1234_5678;
        exp_q.push_back('{port: OWN_D,  data: 32'h0});
        exp_q.push_back('{port: OWN_IF, data: 32'h1234_5678});
        step();
        chk("t2_owner", 32'(bus.owner),  32'(OWN_D));
        chk("t2_be",    32'(bus.mem_be), 32'h3);
        chk("t2_we",    32'(bus.mem_we), 32'd1);
        chk("t2_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
        wait_done("t2d", 1);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        wait_done("t2i", 4);
        chk("t2_d_rdata_kept", bus.d_rdata, 32'h0);
        bus.if_req = 1'b0;
        step(); step();

        // Continuous contention: streak forces IF through every fifth grant
        grant_q = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF, OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF};
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        bus.mem_ready = 1'b1;
        prev_req = bus.mem_req;
        grants = 0;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            step();
            if (bus.mem_req && !prev_req) begin
                eg = grant_q.pop_front();
                chk($sformatf("t3_grant%0d", grants), 32'(bus.owner), 32'(eg));
                grants++;
            end
            prev_req = bus.mem_req;
        end
        chk("t3_grant_count", 32'(grants), 32'd10);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        step(); step(); step(); step();

        // Slow memory: ready withheld for 5 cycles on a load
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        exp_q.push_back('{port: OWN_D, data: 32'h0000_00AA});
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_req_c%0d", c),  32'(bus.mem_req), 32'd1);
            chk($sformatf("t4_addr_c%0d", c), bus.mem_addr,     32'h200);
            chk($sformatf("t4_done_c%0d", c), 32'(bus.d_done),  32'd0);
            if (c < 4) step();
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_00AA;
        wait_done("t4", 1);
        bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        step();
        chk("t4_done_pulse", 32'(bus.d_done), 32'd0);
        step();

        // Reset in the middle of an access
        bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.mem_ready = 1'b0;
        step();
        chk("t5_busy", 32'(bus.mem_req), 32'd1);
        reset = 1'b0;
        step();
        chk("t5_req",     32'(bus.mem_req), 32'd0);
        chk("t5_owner",   32'(bus.owner),   32'd0);
        chk("t5_if_done", 32'(bus.if_done), 32'd0);
        chk("t5_d_rd",    bus.d_rdata,      32'd0);
        chk("t5_addr",    bus.mem_addr,     32'd0);
        reset = 1'b1;
        bus.if_addr = 32'h84; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        exp_q.push_back('{port: OWN_IF, data: 32'h5555_AAAA});
        step();
        chk("t5_fresh_addr", bus.mem_addr, 32'h84);
        wait_done("t5", 1);
        bus.if_req = 1'b0;

        // mem_ready while idle is ignored
        step(); step(); step();
        chk("t5_idle_if_done", 32'(bus.if_done), 32'd0);
        chk("t5_idle_d_done",  32'(bus.d_done),  32'd0);
        chk("t5_idle_req",     32'(bus.mem_req), 32'd0);

        // Data request dropped mid-access still completes once
        bus.mem_ready = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        exp_q.push_back('{port: OWN_D, data: 32'hCAFE_0001});
        step();
        step();
        bus.d_req = 1'b0;
        step();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        wait_done("t6", 1);
        bus.mem_ready = 1'b0;
        step();
        chk("t6_done_once",  32'(bus.d_done), 32'd0);
        chk("t6_owner_idle", 32'(bus.owner),  32'd0);
        step();
        chk("t6_no_regrant", 32'(bus.mem_req), 32'd0);
        chk("t6_d_rdata_hold", bus.d_rdata, 32'hCAFE_0001);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
